// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC pipeline memory stage.
//   WORD_W      : native data/address width of the datapath
//   mem_state_t : sequencing states of the data-memory access controller
package wisc_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    MA_IDLE,
    MA_WAIT,
    MA_DONE
  } mem_state_t;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts WAIT cycles that pass without a memory acknowledge.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear of the count (takes priority over en)
//   en         : count this cycle
//   expired    : count has reached TIMEOUT_CYC-1 while en is high
module mem_timeout_ctr #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] SAT   = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] count;

  // Saturates instead of wrapping so a stuck enable can never re-arm expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != SAT)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = en && (count == LIMIT);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences the data-memory access requested by the EX/MEM register over a
// req/ack handshake to a variable-latency memory, stalling the pipeline until
// the access completes or times out.
// Ports:
//   clk, rst_n        : clock and asynchronous active-low reset
//   mem_to_reg_in     : LW request from EX/MEM
//   reg_to_mem_in     : SW request from EX/MEM
//   alu_result_in     : effective address
//   save_word_data_in : store data
//   mem_rdata/mem_ack : memory read data and completion strobe
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory request
//   stall             : freezes PC, IF/ID, ID/EX, EX/MEM (combinational)
//   ld_data_out       : load result for MEM/WB
//   ld_valid          : one-cycle strobe, ld_data_out valid (DONE of a load)
//   mem_err           : sticky error, timeout or simultaneous LW+SW
module mem_access_ctrl
  import wisc_pkg::*;
#(
  parameter int DATA_W      = WORD_W,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_to_reg_in,
  input  logic              reg_to_mem_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] save_word_data_in,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              stall,
  output logic [DATA_W-1:0] ld_data_out,
  output logic              ld_valid,
  output logic              mem_err
);

  mem_state_t state, state_nxt;

  logic              access;
  logic              expired;
  logic              req_nxt, we_nxt, valid_nxt, err_nxt;
  logic [DATA_W-1:0] addr_nxt, wdata_nxt, ld_data_nxt;

  assign access = mem_to_reg_in || reg_to_mem_in;
  assign stall  = ((state == MA_IDLE) && access) || (state == MA_WAIT);

  mem_timeout_ctr #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state != MA_WAIT),
    .en      ((state == MA_WAIT) && !mem_ack),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MA_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MA_IDLE: if (access) state_nxt = MA_WAIT;
      MA_WAIT: if (mem_ack || expired) state_nxt = MA_DONE;
      MA_DONE: state_nxt = MA_IDLE;
      default: state_nxt = MA_IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless changed.
  always_comb begin
    req_nxt     = mem_req;
    we_nxt      = mem_we;
    addr_nxt    = mem_addr;
    wdata_nxt   = mem_wdata;
    ld_data_nxt = ld_data_out;
    err_nxt     = mem_err;
    valid_nxt   = 1'b0;
    case (state)
      MA_IDLE: begin
        if (access) begin
          req_nxt   = 1'b1;
          we_nxt    = reg_to_mem_in;  // store wins a simultaneous LW+SW
          addr_nxt  = alu_result_in;
          wdata_nxt = save_word_data_in;
          if (mem_to_reg_in && reg_to_mem_in) err_nxt = 1'b1;
        end
      end
      MA_WAIT: begin
        if (mem_ack) begin
          req_nxt = 1'b0;
          if (!mem_we) begin
            ld_data_nxt = mem_rdata;
            valid_nxt   = 1'b1;
          end
        end else if (expired) begin
          req_nxt     = 1'b0;
          err_nxt     = 1'b1;
          ld_data_nxt = '0;
          valid_nxt   = !mem_we;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ld_data_out <= '0;
      ld_valid    <= 1'b0;
      mem_err     <= 1'b0;
    end else begin
      mem_req     <= req_nxt;
      mem_we      <= we_nxt;
      mem_addr    <= addr_nxt;
      mem_wdata   <= wdata_nxt;
      ld_data_out <= ld_data_nxt;
      ld_valid    <= valid_nxt;
      mem_err     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int DW  = 16;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mem_to_reg_in, reg_to_mem_in;
  logic [DW-1:0] alu_result_in, save_word_data_in, mem_rdata;
  logic          mem_ack;
  logic          mem_req, mem_we, stall, ld_valid, mem_err;
  logic [DW-1:0] mem_addr, mem_wdata, ld_data_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [DW-1:0] exp_ld_q[$];
  bit exp_err = 1'b0;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .DATA_W      (DW),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem_to_reg_in     (mem_to_reg_in),
    .reg_to_mem_in     (reg_to_mem_in),
    .alu_result_in     (alu_result_in),
    .save_word_data_in (save_word_data_in),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .stall             (stall),
    .ld_data_out       (ld_data_out),
    .ld_valid          (ld_valid),
    .mem_err           (mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every ld_valid pulse must match the oldest expected load.
  always @(negedge clk) begin
    if (rst_n && ld_valid) begin
      if (exp_ld_q.size() == 0) check("ld_unexpected", 32'(ld_valid), 32'd0);
      else check("ld_data", 32'(ld_data_out), 32'(exp_ld_q.pop_front()));
    end
  end

  // ack_wait: ack given on that WAIT cycle (1-based); 0 means never.
  task automatic do_access(input bit lw, input bit sw, input logic [DW-1:0] addr,
                           input logic [DW-1:0] wdata, input int ack_wait,
                           input logic [DW-1:0] rdata);
    int stall_cnt = 0;
    int req_cnt   = 0;
    int first_req = -1;
    bit bad  = 1'b0;
    bit done = 1'b0;
    int exp_cyc;
    @(negedge clk);
    mem_to_reg_in = lw;  reg_to_mem_in = sw;
    alu_result_in = addr; save_word_data_in = wdata;
    if (lw && !sw) exp_ld_q.push_back((ack_wait != 0) ? rdata : 16'h0000);
    if ((lw && sw) || ack_wait == 0) exp_err = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        if (first_req < 0) first_req = c;
        if (mem_addr !== addr || mem_wdata !== wdata || mem_we !== sw) bad = 1'b1;
      end
      if (!stall) begin
        done = 1'b1;
        check("ld_valid_done", 32'(ld_valid), 32'(lw && !sw));
        mem_to_reg_in = 1'b0; reg_to_mem_in = 1'b0; mem_ack = 1'b0;
      end else begin
        if (mem_req && ack_wait != 0 && req_cnt == ack_wait) begin
          mem_ack = 1'b1; mem_rdata = rdata;
        end else begin
          mem_ack = 1'b0; mem_rdata = 16'($urandom);
        end
        @(negedge clk);
      end
    end
    exp_cyc = (ack_wait != 0) ? ack_wait : TMO;
    check("done_bound", 32'(done), 32'd1);
    check("stall_cycles", 32'(stall_cnt), 32'(exp_cyc + 1));
    check("req_cycles", 32'(req_cnt), 32'(exp_cyc));
    check("req_rise", 32'(first_req), 32'd1);
    check("req_fields", 32'(bad), 32'd0);
    check("mem_err", 32'(mem_err), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit lw;
    rst_n = 1'b0;
    mem_to_reg_in = 1'b0; reg_to_mem_in = 1'b0;
    alu_result_in = '0; save_word_data_in = '0; mem_rdata = '0; mem_ack = 1'b0;
    #1;
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_we",    32'(mem_we), 32'd0);
    check("rst_addr",  32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_ld",    32'(ld_data_out), 32'd0);
    check("rst_valid", 32'(ld_valid), 32'd0);
    check("rst_err",   32'(mem_err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_access(1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF);

    // Stray ack while idle must not disturb anything.
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("stray_req",   32'(mem_req), 32'd0);
    check("stray_valid", 32'(ld_valid), 32'd0);
    check("stray_data",  32'(ld_data_out), 32'h0000BEEF);

    do_access(1'b0, 1'b1, 16'h0010, 16'h1234, 4, 16'h0000);
    do_access(1'b1, 1'b0, 16'h0050, 16'h0000, 2, 16'h5A5A);
    do_access(1'b1, 1'b0, 16'h0060, 16'h0000, 0, 16'h0000);
    do_access(1'b0, 1'b1, 16'h0064, 16'h7777, 1, 16'h0000);

    // Reset asserted in the middle of a WAIT.
    @(negedge clk);
    mem_to_reg_in = 1'b1; alu_result_in = 16'h0070;
    @(negedge clk);
    @(negedge clk);
    #1 check("mid_req_pre", 32'(mem_req), 32'd1);
    #2;
    rst_n = 1'b0; mem_to_reg_in = 1'b0;
    #1;
    check("mid_req",   32'(mem_req), 32'd0);
    check("mid_stall", 32'(stall), 32'd0);
    check("mid_err",   32'(mem_err), 32'd0);
    check("mid_addr",  32'(mem_addr), 32'd0);
    exp_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_access(1'b1, 1'b0, 16'h0080, 16'h0000, 1, 16'h1111);
    do_access(1'b1, 1'b0, 16'h0084, 16'h0000, 1, 16'hAAAA);
    do_access(1'b1, 1'b0, 16'h0088, 16'h0000, 1, 16'h5555);
    do_access(1'b1, 1'b1, 16'h0020, 16'hC0DE, 1, 16'h0000);

    for (int i = 0; i < 6; i++) begin
      lw = 1'($urandom_range(0, 1));
      do_access(lw, !lw, 16'($urandom), 16'($urandom),
                int'($urandom_range(1, 5)), 16'($urandom));
    end

    @(negedge clk);
    check("ld_queue_empty", 32'(exp_ld_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
